melody_player: RTL and testbench

//  Parametrised multi-tune buzzer sequencer for the door-lock front panel.
//  NUM_TUNES level triggers select tunes from a fixed table. Each tune is a

---
 rtl/melody_pkg.sv | 79 +++++++
 rtl/tone_gen.sv | 51 +++++
 rtl/melody_player.sv | 199 +++++++++++++++++++
 tb/tb_melody_player.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/melody_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : melody_pkg
//  Purpose  : Shared definitions for the melody player: note pitches, the
//             fixed tune table, loop flags and FSM state encodings.
//             The MELODY_GAP_EN build option only affects melody_player.
//  Revision : 1.0  initial release
// ============================================================================
package melody_pkg;

    localparam int NOTE_TONE_W = 16;
    localparam int NOTE_DUR_W  = 4;

    // Half-period values in CLK cycles at 24 MHz
    localparam logic [NOTE_TONE_W-1:0] NOTE_REST  = 16'd0;
    localparam logic [NOTE_TONE_W-1:0] NOTE_DO    = 16'd11659;
    localparam logic [NOTE_TONE_W-1:0] NOTE_MI    = 16'd9253;
    localparam logic [NOTE_TONE_W-1:0] NOTE_SOL   = 16'd7782;
    localparam logic [NOTE_TONE_W-1:0] NOTE_HDO   = 16'd5827;
    localparam logic [NOTE_TONE_W-1:0] NOTE_ALARM = 16'd5192;

    // Bit n set means tune n restarts while its trigger stays high
    localparam logic [7:0] TUNE_LOOP_MASK = 8'b0000_0010;

    // dur is the last field so it occupies the low bits of the packed word
    typedef struct packed {
        logic [NOTE_TONE_W-1:0] tone;
        logic [NOTE_DUR_W-1:0]  dur;
    } note_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    // Fixed tune ROM; unlisted slots and unused tunes are end markers (dur 0)
    function automatic note_t tune_note(input logic [2:0] tune, input int idx);
        note_t n;
        n = '0;
        case (tune)
            3'd0: case (idx)
                0: n = {NOTE_DO,    4'd1};
                1: n = {NOTE_MI,    4'd1};
                2: n = {NOTE_SOL,   4'd1};
                3: n = {NOTE_HDO,   4'd1};
                default: n = '0;
            endcase
            3'd1: case (idx)
                0: n = {NOTE_ALARM, 4'd2};
                1: n = {NOTE_REST,  4'd2};
                default: n = '0;
            endcase
            3'd2: case (idx)
                0: n = {NOTE_HDO,   4'd1};
                1: n = {NOTE_SOL,   4'd1};
                2: n = {NOTE_MI,    4'd1};
                3: n = {NOTE_DO,    4'd1};
                default: n = '0;
            endcase
            3'd3: case (idx)
                0: n = {NOTE_ALARM, 4'd1};
                1: n = {NOTE_REST,  4'd1};
                2: n = {NOTE_ALARM, 4'd1};
                default: n = '0;
            endcase
            default: n = '0;
        endcase
        return n;
    endfunction

    // Duration field only, used for end-marker look-ahead
    function automatic logic [NOTE_DUR_W-1:0] tune_dur(input logic [2:0] tune, input int idx);
        return NOTE_DUR_W'(tune_note(tune, idx));
    endfunction

endpackage
`default_nettype wire

// File: rtl/tone_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tone_gen
//  Purpose  : Square-wave divider for an active-low piezo. Half-period is
//             tone+1 cycles; tone 0 is a rest (output held at 1). load
//             restarts the wave silent with the counter cleared.
//  Revision : 1.0  initial release
// ============================================================================
module tone_gen #(
    parameter int TONE_W = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [TONE_W-1:0] tone,
    input  logic              load,
    output logic              BUZZER
);

    logic [TONE_W-1:0] cnt_q, cnt_d;
    logic              buz_q, buz_d;

    // Next counter/output: load and rests force silence, else toggle at cnt==tone
    always_comb begin
        cnt_d = cnt_q;
        buz_d = buz_q;
        if (load || (tone == '0)) begin
            cnt_d = '0;
            buz_d = 1'b1;
        end else if (cnt_q == tone) begin
            cnt_d = '0;
            buz_d = ~buz_q;
        end else begin
            cnt_d = cnt_q + TONE_W'(1);
        end
    end

    // Divider registers, silent on reset
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt_q <= '0;
            buz_q <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            buz_q <= buz_d;
        end
    end

    assign BUZZER = buz_q;

endmodule
`default_nettype wire

// File: rtl/melody_player.sv
`default_nettype none
// ============================================================================
//  Module   : melody_player
//  Purpose  : Multi-tune buzzer sequencer. Priority-encoded level triggers
//             select a tune from the melody_pkg table; one-shot tunes hold
//             silent until released, looping tunes repeat while held.
//             Build option MELODY_GAP_EN inserts GAP_CYCLES of silence
//             between consecutive notes of a tune.
//  Revision : 1.0  initial release
// ============================================================================
module melody_player
    import melody_pkg::*;
#(
    parameter int NUM_TUNES   = 4,
    parameter int MAX_NOTES   = 8,
    parameter int TONE_W      = 16,
    parameter int TICK_CYCLES = 2_400_000,
    parameter int GAP_CYCLES  = 240_000
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [NUM_TUNES-1:0] trig,
    output logic                 busy,
    output logic [2:0]           tune_id,
    output logic                 done,
    output logic                 BUZZER
);

    localparam int IDX_W  = $clog2(MAX_NOTES);
    localparam int TICK_W = $clog2(TICK_CYCLES + 1);

    state_t                state_q, state_d;
    logic [2:0]            tune_q, tune_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  done_q, done_d;
    logic [TICK_W-1:0]     tick_cnt_q;
    logic [NOTE_DUR_W-1:0] dur_cnt_q;

    logic       note_load;
    logic       tone_load;
    logic [7:0] trig_ext;
    logic       req_any;
    logic [2:0] req_idx;
    note_t      cur_note;
    logic       tick;
    logic       note_end;
    logic       note_last;
    logic       tune_loops;
    logic       tune_held;
    logic       gap_done;

    assign trig_ext   = 8'(trig);
    assign tune_held  = trig_ext[tune_q];
    assign tune_loops = TUNE_LOOP_MASK[tune_q];
    assign cur_note   = tune_note(tune_q, int'(idx_q));
    assign tick       = (tick_cnt_q == TICK_W'(TICK_CYCLES - 1));
    // A dur-0 slot ends the tune immediately (covers empty tunes)
    assign note_end   = (cur_note.dur == '0) ||
                        (tick && (dur_cnt_q == cur_note.dur - NOTE_DUR_W'(1)));
    // Look ahead so the done pulse follows the last note without a dead cycle
    assign note_last  = (idx_q == IDX_W'(MAX_NOTES - 1)) ||
                        (tune_dur(tune_q, int'(idx_q) + 1) == '0);

    // Priority encoder: lowest set trigger index wins
    always_comb begin
        req_any = 1'b0;
        req_idx = '0;
        for (int i = NUM_TUNES - 1; i >= 0; i--) begin
            if (trig[i]) begin
                req_any = 1'b1;
                req_idx = 3'(i);
            end
        end
    end

`ifdef MELODY_GAP_EN
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    logic [GAP_W-1:0] gap_cnt_q;

    assign gap_done = (gap_cnt_q == GAP_W'(GAP_CYCLES - 1));

    // Inter-note silence counter, idle at zero outside GAP
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            gap_cnt_q <= '0;
        end else if (state_q != ST_GAP) begin
            gap_cnt_q <= '0;
        end else begin
            gap_cnt_q <= gap_cnt_q + GAP_W'(1);
        end
    end
`else
    assign gap_done = 1'b0;
`endif

    // Sequencer next state: preemption, then release, then note progress
    always_comb begin
        state_d   = state_q;
        tune_d    = tune_q;
        idx_d     = idx_q;
        done_d    = 1'b0;
        note_load = 1'b0;
        if (state_q == ST_IDLE) begin
            if (req_any) begin
                state_d   = ST_PLAY;
                tune_d    = req_idx;
                idx_d     = '0;
                note_load = 1'b1;
            end
        end else if (req_any && (req_idx < tune_q)) begin
            state_d   = ST_PLAY;
            tune_d    = req_idx;
            idx_d     = '0;
            note_load = 1'b1;
        end else if (state_q == ST_HOLD) begin
            if (!tune_held) begin
                state_d = ST_IDLE;
            end
        end else if (tune_loops && !tune_held) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
        end else if (state_q == ST_PLAY) begin
            if (note_end) begin
                if (note_last) begin
                    if (tune_loops) begin
                        idx_d     = '0;
                        note_load = 1'b1;
                    end else begin
                        done_d  = 1'b1;
                        state_d = ST_HOLD;
                    end
                end else begin
                    idx_d = idx_q + IDX_W'(1);
`ifdef MELODY_GAP_EN
                    state_d = ST_GAP;
`else
                    note_load = 1'b1;
`endif
                end
            end
        end else if (gap_done) begin
            state_d   = ST_PLAY;
            note_load = 1'b1;
        end
    end

    // Tone generator restarts silent on every note load and whenever not playing
    assign tone_load = note_load || (state_d != ST_PLAY);

    // FSM and tune/note registers
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            tune_q  <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tune_q  <= tune_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    // Tick prescaler restarted on note load; duration counter counts ticks
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            tick_cnt_q <= '0;
            dur_cnt_q  <= '0;
        end else begin
            if (note_load || tick) begin
                tick_cnt_q <= '0;
            end else begin
                tick_cnt_q <= tick_cnt_q + TICK_W'(1);
            end
            if (note_load) begin
                dur_cnt_q <= '0;
            end else if ((state_q == ST_PLAY) && tick) begin
                dur_cnt_q <= dur_cnt_q + NOTE_DUR_W'(1);
            end
        end
    end

    tone_gen #(
        .TONE_W (TONE_W)
    ) u_tone_gen (
        .CLK    (CLK),
        .RESET  (RESET),
        .tone   ((state_q == ST_PLAY) ? TONE_W'(cur_note.tone) : '0),
        .load   (tone_load),
        .BUZZER (BUZZER)
    );

    assign busy    = (state_q == ST_PLAY) || (state_q == ST_GAP);
    assign tune_id = tune_q;
    assign done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_melody_player.sv
`default_nettype none
// ============================================================================
//  Module   : tb_melody_player
//  Purpose  : Self-checking bench for melody_player with a per-cycle
//             behavioural model built from the tune table and play rules.
//             A second instance with long ticks exercises audible toggling.
//  Revision : 1.0  initial release
// ============================================================================
module tb_melody_player;

    localparam int TK      = 10;
    localparam int GP      = 3;
    localparam int MN      = 8;
    localparam int SLOW_TK = 6000;
`ifdef MELODY_GAP_EN
    localparam int G = GP;
`else
    localparam int G = 0;
`endif
    localparam int S_IDLE = 0, S_PLAY = 1, S_GAP = 2, S_HOLD = 3;
    localparam int LOOP_TUNE = 1;

    logic       CLK;
    logic       RESET;
    logic [3:0] trig, trig_s;
    logic       busy, done, BUZZER;
    logic [2:0] tune_id;
    logic       busy_s, done_s, BUZZER_s;
    logic [2:0] tune_id_s;

    int passed, total;

    // model state
    int   m_tone [4][9];
    int   m_dur  [4][9];
    int   m_st, m_tune, m_note, m_el, m_gel;
    logic m_done;

    melody_player #(
        .NUM_TUNES(4), .MAX_NOTES(MN), .TONE_W(16), .TICK_CYCLES(TK), .GAP_CYCLES(GP)
    ) u_dut (
        .CLK(CLK), .RESET(RESET), .trig(trig),
        .busy(busy), .tune_id(tune_id), .done(done), .BUZZER(BUZZER)
    );

    melody_player #(
        .NUM_TUNES(4), .MAX_NOTES(MN), .TONE_W(16), .TICK_CYCLES(SLOW_TK), .GAP_CYCLES(GP)
    ) u_slow (
        .CLK(CLK), .RESET(RESET), .trig(trig_s),
        .busy(busy_s), .tune_id(tune_id_s), .done(done_s), .BUZZER(BUZZER_s)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic model_reset();
        m_st = S_IDLE; m_tune = 0; m_note = 0; m_el = 0; m_gel = 0; m_done = 1'b0;
    endtask

    task automatic model_start(input int t);
        m_tune = t; m_st = S_PLAY; m_note = 0; m_el = 0;
    endtask

    // One clock edge of the reference behaviour given the sampled triggers
    task automatic model_edge(input logic [3:0] t);
        int hp;
        hp = -1;
        for (int i = 3; i >= 0; i--) if (t[i]) hp = i;
        m_done = 1'b0;
        if (m_st == S_IDLE) begin
            if (hp >= 0) model_start(hp);
        end else if (hp >= 0 && hp < m_tune) begin
            model_start(hp);
        end else if (m_st == S_HOLD) begin
            if (!t[m_tune]) m_st = S_IDLE;
        end else if (m_tune == LOOP_TUNE && !t[m_tune]) begin
            m_done = 1'b1; m_st = S_IDLE;
        end else if (m_st == S_GAP) begin
            m_gel++;
            if (m_gel == GP) begin m_st = S_PLAY; m_note++; m_el = 0; end
        end else begin
            m_el++;
            if (m_el == m_dur[m_tune][m_note] * TK) begin
                if (m_note == MN - 1 || m_dur[m_tune][m_note + 1] == 0) begin
                    if (m_tune == LOOP_TUNE) begin m_note = 0; m_el = 0; end
                    else begin m_done = 1'b1; m_st = S_HOLD; end
                end else if (G != 0) begin
                    m_st = S_GAP; m_gel = 0;
                end else begin
                    m_note++; m_el = 0;
                end
            end
        end
    endtask

    // Expected {busy, done, tune_id, BUZZER}; wave is 1 for the first tone+1 cycles of a note
    function automatic logic [5:0] exp_vec();
        logic b;
        int   tn;
        b = 1'b1;
        if (m_st == S_PLAY) begin
            tn = m_tone[m_tune][m_note];
            if (tn != 0 && ((m_el / (tn + 1)) % 2) == 1) b = 1'b0;
        end
        return {(m_st == S_PLAY || m_st == S_GAP), m_done, 3'(m_tune), b};
    endfunction

    // Drive triggers, advance one clock, update model, settle at falling edge
    task automatic cyc(input logic [3:0] t);
        trig = t;
        @(posedge CLK);
        model_edge(t);
        @(negedge CLK);
    endtask

    task automatic go_idle();
        for (int i = 0; i < 60; i++) cyc(4'b0000);
    endtask

    task automatic test_reset();
        total++;
        if ({busy, done, tune_id, BUZZER} !== exp_vec() || exp_vec() !== 6'b000001)
            $display("FAIL reset main got=%b exp=%b", {busy, done, tune_id, BUZZER}, 6'b000001);
        else passed++;
        total++;
        if ({busy_s, done_s, tune_id_s, BUZZER_s} !== 6'b000001)
            $display("FAIL reset slow got=%b exp=%b", {busy_s, done_s, tune_id_s, BUZZER_s}, 6'b000001);
        else passed++;
    endtask

    task automatic test_open_chime();
        for (int c = 1; c <= 45 + 3 * G; c++) begin
            cyc(4'b0001);
            total++;
            if ({busy, done, tune_id, BUZZER} !== exp_vec())
                $display("FAIL open_chime c=%0d got=%b exp=%b", c, {busy, done, tune_id, BUZZER}, exp_vec());
            else passed++;
            total++;
            if (done !== (c == 41 + 3 * G))
                $display("FAIL open_done_cycle c=%0d got=%b exp=%b", c, done, (c == 41 + 3 * G));
            else passed++;
        end
        total++;
        if (busy !== 1'b0 || BUZZER !== 1'b1)
            $display("FAIL open_hold got busy=%b buz=%b exp busy=0 buz=1", busy, BUZZER);
        else passed++;
        cyc(4'b0000);
        cyc(4'b0001);
        total++;
        if ({busy, tune_id} !== 4'b1000 || exp_vec() !== {busy, done, tune_id, BUZZER})
            $display("FAIL open_retrigger got=%b exp=%b", {busy, done, tune_id, BUZZER}, exp_vec());
        else passed++;
        go_idle();
    endtask

    task automatic test_alarm_loop();
        for (int c = 1; c <= 100; c++) begin
            cyc(4'b0010);
            total++;
            if ({busy, done, tune_id, BUZZER} !== exp_vec() || busy !== 1'b1 || done !== 1'b0)
                $display("FAIL alarm_loop c=%0d got=%b exp=%b", c, {busy, done, tune_id, BUZZER}, exp_vec());
            else passed++;
        end
        cyc(4'b0000);
        total++;
        if ({BUZZER, done, busy} !== 3'b110 || exp_vec() !== {busy, done, tune_id, BUZZER})
            $display("FAIL alarm_release got buz,done,busy=%b exp=110", {BUZZER, done, busy});
        else passed++;
        go_idle();
    endtask

    task automatic test_preempt();
        for (int c = 0; c < 15; c++) cyc(4'b0100);
        cyc(4'b0101);
        total++;
        if ({busy, done, tune_id} !== 5'b10000)
            $display("FAIL preempt_switch got=%b exp=10000", {busy, done, tune_id});
        else passed++;
        for (int c = 1; c <= 60; c++) begin
            cyc(4'b0001);
            total++;
            if ({busy, done, tune_id, BUZZER} !== exp_vec())
                $display("FAIL preempt_run c=%0d got=%b exp=%b", c, {busy, done, tune_id, BUZZER}, exp_vec());
            else passed++;
        end
        go_idle();
    endtask

    task automatic test_simultaneous();
        cyc(4'b1100);
        total++;
        if (tune_id !== 3'd2 || busy !== 1'b1)
            $display("FAIL simul_pick got=%0d exp=2", tune_id);
        else passed++;
        for (int c = 1; c <= 70; c++) begin
            cyc(4'b1000);
            total++;
            if ({busy, done, tune_id, BUZZER} !== exp_vec() || (c <= 40 && tune_id !== 3'd2))
                $display("FAIL simul_low_ignored c=%0d got=%b exp=%b", c, {busy, done, tune_id, BUZZER}, exp_vec());
            else passed++;
        end
        go_idle();
    endtask

    task automatic test_random();
        logic [3:0] t;
        t = 4'b0000;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 19) == 0) t = 4'($urandom) & 4'($urandom);
            cyc(t);
            total++;
            if ({busy, done, tune_id, BUZZER} !== exp_vec())
                $display("FAIL random c=%0d trig=%b got=%b exp=%b", c, t, {busy, done, tune_id, BUZZER}, exp_vec());
            else passed++;
        end
        go_idle();
    endtask

    // Long ticks make ALARM audible: tune 3 expected from closed-form timeline
    task automatic test_slow_tone();
        int len, per, pos, n, el, tn;
        logic [5:0] e;
        len = 3 * SLOW_TK + 2 * G;
        per = SLOW_TK + G;
        trig_s = 4'b1000;
        for (int c = 1; c <= len + 3; c++) begin
            cyc(4'b0000);
            if (c <= len) begin
                pos = c - 1; n = pos / per; el = pos % per;
                tn = (n == 1) ? 0 : 5192;
                e = {2'b10, 3'd3, (el >= SLOW_TK || tn == 0 || ((el / (tn + 1)) % 2) == 0)};
            end else begin
                e = {1'b0, (c == len + 1), 3'd3, 1'b1};
            end
            total++;
            if ({busy_s, done_s, tune_id_s, BUZZER_s} !== e)
                $display("FAIL slow_tone c=%0d got=%b exp=%b", c, {busy_s, done_s, tune_id_s, BUZZER_s}, e);
            else passed++;
        end
        trig_s = 4'b0000;
        cyc(4'b0000);
        cyc(4'b0000);
        trig_s = 4'b1000;
        for (int c = 1; c <= 5300; c++) cyc(4'b0000);
        total++;
        if (BUZZER_s !== 1'b0)
            $display("FAIL slow_low_phase got=%b exp=0", BUZZER_s);
        else passed++;
        #2 RESET = 1'b1;
        #1;
        total++;
        if ({busy_s, BUZZER_s} !== 2'b01)
            $display("FAIL slow_async_reset got busy,buz=%b exp=01", {busy_s, BUZZER_s});
        else passed++;
        trig_s = 4'b0000;
        model_reset();
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 5; c++) cyc(4'b0001);
        total++;
        if (busy !== 1'b1)
            $display("FAIL reset_mid_pre got busy=%b exp=1", busy);
        else passed++;
        #2 RESET = 1'b1;
        #1;
        total++;
        if ({busy, done, tune_id, BUZZER} !== 6'b000001)
            $display("FAIL reset_mid_async got=%b exp=000001", {busy, done, tune_id, BUZZER});
        else passed++;
        trig = 4'b0000;
        model_reset();
        @(negedge CLK);
        RESET = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            cyc(4'b0000);
            total++;
            if ({busy, done, tune_id, BUZZER} !== exp_vec() || BUZZER !== 1'b1)
                $display("FAIL reset_mid_after c=%0d got=%b exp=%b", c, {busy, done, tune_id, BUZZER}, exp_vec());
            else passed++;
        end
    endtask

    initial begin
        passed = 0;
        total  = 0;
        m_tone = '{'{11659, 9253, 7782, 5827, 0, 0, 0, 0, 0},
                   '{5192, 0, 0, 0, 0, 0, 0, 0, 0},
                   '{5827, 7782, 9253, 11659, 0, 0, 0, 0, 0},
                   '{5192, 0, 5192, 0, 0, 0, 0, 0, 0}};
        m_dur  = '{'{1, 1, 1, 1, 0, 0, 0, 0, 0},
                   '{2, 2, 0, 0, 0, 0, 0, 0, 0},
                   '{1, 1, 1, 1, 0, 0, 0, 0, 0},
                   '{1, 1, 1, 0, 0, 0, 0, 0, 0}};
        model_reset();
        RESET  = 1'b1;
        trig   = 4'b0000;
        trig_s = 4'b0000;
        repeat (3) @(negedge CLK);
        test_reset();
        RESET = 1'b0;
        test_open_chime();
        test_alarm_loop();
        test_preempt();
        test_simultaneous();
        test_random();
        test_slow_tone();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
